// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store path, one transaction at a time.
// Optional bus-timeout watchdog is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_DM = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX out of range 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 1..255");
  end

  logic [1:0]    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          idle;

  assign idle   = (state_q == ST_IDLE);
  assign dm_gnt = idle & dm_req & ~(if_req & (starve_q == STARVE_LIM));
  assign if_gnt = idle & if_req & ~dm_gnt;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] tmo_q, tmo_d;
  logic       if_err_q, if_err_d;
  logic       dm_err_q, dm_err_d;
  logic       tmo_hit;
  assign tmo_hit = ~idle & ~mem_ack & (tmo_q == TMO_LIM);
`endif

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    if_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dm_gnt) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ST_BUSY_DM;
          // Count only data grants that actually made fetch wait.
          if (!if_req)                  starve_d = '0;
          else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
        end else if (if_gnt) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ST_BUSY_IF;
          starve_d    = '0;
        end else if (!if_req) begin
          starve_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      ST_BUSY_IF, ST_BUSY_DM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (state_q == ST_BUSY_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_hit) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (state_q == ST_BUSY_IF) begin
            if_done_d  = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_done_d  = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q    <= '0;
      if_err_q <= 1'b0;
      dm_err_q <= 1'b0;
    end else begin
      tmo_q    <= tmo_d;
      if_err_q <= if_err_d;
      dm_err_q <= dm_err_d;
    end
  end
  assign if_err = if_err_q;
  assign dm_err = dm_err_q;
`else
  assign if_err = 1'b0;
  assign dm_err = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; completions are checked against a scoreboard of expected done pulses.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_gnt, if_done, if_err, dm_gnt, dm_done, dm_err;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;

  typedef struct {
    logic          is_dm;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT_CYC(5)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_dm, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  // Completion monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (if_done || dm_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {62'd0, if_done, dm_done}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_which", {62'd0, if_done, dm_done}, e.is_dm ? 64'd1 : 64'd2);
        chk("sb_rdata", e.is_dm ? 64'(dm_rdata) : 64'(if_rdata), 64'(e.rdata));
        chk("sb_err", e.is_dm ? 64'(dm_err) : 64'(if_err), 64'(e.err));
      end
    end
  end

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    nx(); nx();
    rst = 1'b0;
    nx();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_done", {62'd0, if_done, dm_done}, 64'd0);
    chk("rst_err", {62'd0, if_err, dm_err}, 64'd0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 64'd0);

    // Single fetch, zero-wait memory
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF; mem_ack = 1'b1;
    #1;
    chk("f1_if_gnt", 64'(if_gnt), 64'd1);
    chk("f1_dm_gnt", 64'(dm_gnt), 64'd0);
    push(1'b0, 32'hDEADBEEF, 1'b0);
    nx();
    if_req = 1'b0;
    #1;
    chk("f1_mem_req", 64'(mem_req), 64'd1);
    chk("f1_mem_addr", 64'(mem_addr), 64'h10);
    chk("f1_mem_we", 64'(mem_we), 64'd0);
    nx();
    chk("f1_if_done", 64'(if_done), 64'd1);
    chk("f1_if_rdata", 64'(if_rdata), 64'hDEADBEEF);
    chk("f1_mem_req_off", 64'(mem_req), 64'd0);
    nx();
    chk("f1_done_pulse", 64'(if_done), 64'd0);

    // Simultaneous requests: store wins, then fetch
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
    #1;
    chk("s_dm_gnt", 64'(dm_gnt), 64'd1);
    chk("s_if_gnt", 64'(if_gnt), 64'd0);
    push(1'b1, 32'h0, 1'b0);
    nx();
    dm_req = 1'b0;
    #1;
    chk("s_mem_we", 64'(mem_we), 64'd1);
    chk("s_mem_wdata", 64'(mem_wdata), 64'h55);
    chk("s_mem_addr", 64'(mem_addr), 64'h20);
    chk("s_busy_gnt", {62'd0, if_gnt, dm_gnt}, 64'd0);
    nx();
    mem_rdata = 32'h12345678;
    #1;
    chk("s_dm_done", 64'(dm_done), 64'd1);
    chk("s_dm_rdata_kept", 64'(dm_rdata), 64'd0);
    chk("s_if_gnt2", 64'(if_gnt), 64'd1);
    push(1'b0, 32'h12345678, 1'b0);
    nx();
    if_req = 1'b0;
    #1;
    chk("s_f_addr", 64'(mem_addr), 64'h30);
    chk("s_f_we", 64'(mem_we), 64'd0);
    chk("s_f_wdata", 64'(mem_wdata), 64'd0);
    nx();
    chk("s_if_done", 64'(if_done), 64'd1);

    // Starvation guard: D,D,D,D,F repeating
    for (int i = 0; i < 10; i++) begin
      nx();
      if_req = 1'b1; if_addr = 32'h200 + i;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100 + i;
      mem_rdata = 32'h1000 + i;
      #1;
      chk($sformatf("st%0d_dm_gnt", i), 64'(dm_gnt), (i % 5 == 4) ? 64'd0 : 64'd1);
      chk($sformatf("st%0d_if_gnt", i), 64'(if_gnt), (i % 5 == 4) ? 64'd1 : 64'd0);
      push((i % 5 != 4), 32'h1000 + i, 1'b0);
      nx();
      chk($sformatf("st%0d_addr", i), 64'(mem_addr), (i % 5 == 4) ? 64'(32'h200 + i) : 64'(32'h100 + i));
      chk($sformatf("st%0d_busy", i), {62'd0, if_gnt, dm_gnt}, 64'd0);
    end
    nx();
    if_req = 1'b0; dm_req = 1'b0;

    // Wait states: ack withheld for 3 busy cycles
    nx();
    mem_ack = 1'b0; if_req = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; mem_rdata = 32'hA5A5;
    #1;
    chk("w_dm_gnt", 64'(dm_gnt), 64'd1);
    push(1'b1, 32'hCAFE0000, 1'b0);
    nx();
    dm_req = 1'b0; dm_addr = 32'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("w%0d_mem", k), {mem_req, mem_we, 30'd0, mem_addr}, {1'b1, 1'b0, 30'd0, 32'h44});
      chk($sformatf("w%0d_gnt", k), {62'd0, if_gnt, dm_gnt}, 64'd0);
      chk($sformatf("w%0d_done", k), 64'(dm_done), 64'd0);
      nx();
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0000; if_req = 1'b0;
    nx();
    mem_ack = 1'b0;
    chk("w_dm_done", 64'(dm_done), 64'd1);
    chk("w_dm_rdata", 64'(dm_rdata), 64'hCAFE0000);

    // Reset mid-BUSY_DM followed by a late ack
    nx();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h88; dm_wdata = 32'h77;
    #1;
    chk("r_dm_gnt", 64'(dm_gnt), 64'd1);
    nx();
    dm_req = 1'b0;
    chk("r_busy", {62'd0, mem_req, mem_we}, 64'd3);
    nx();
    rst = 1'b1;
    nx();
    rst = 1'b0; mem_ack = 1'b1;
    chk("r_mem_req", 64'(mem_req), 64'd0);
    chk("r_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    chk("r_rdata", {if_rdata, dm_rdata}, 64'd0);
    nx();
    chk("r_no_done", {62'd0, if_done, dm_done}, 64'd0);
    chk("r_late_ack_req", 64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    nx();
    chk("r_no_done2", 64'(dm_done), 64'd0);

`ifdef ARB_TIMEOUT_EN
    // Timeout abort, then ack on the timeout edge
    for (int run = 0; run < 2; run++) begin
      nx();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h99; mem_rdata = 32'h5A5A;
      #1;
      chk($sformatf("t%0d_gnt", run), 64'(dm_gnt), 64'd1);
      push(1'b1, (run == 0) ? 32'h0 : 32'h5A5A, (run == 0) ? 1'b1 : 1'b0);
      for (int k = 1; k <= 7; k++) begin
        nx();
        dm_req = 1'b0;
        mem_ack = (run == 1 && k == 6);
        if (k < 7) begin
          chk($sformatf("t%0d_c%0d_done", run, k), 64'(dm_done), 64'd0);
          chk($sformatf("t%0d_c%0d_req", run, k), 64'(mem_req), 64'd1);
        end else begin
          chk($sformatf("t%0d_done", run), 64'(dm_done), 64'd1);
          chk($sformatf("t%0d_err", run), 64'(dm_err), (run == 0) ? 64'd1 : 64'd0);
          chk($sformatf("t%0d_rdata", run), 64'(dm_rdata), (run == 0) ? 64'd0 : 64'h5A5A);
          chk($sformatf("t%0d_req_off", run), 64'(mem_req), 64'd0);
        end
      end
    end
`endif

    nx(); nx();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory between the CPU fetch stage and the load/store data path. It sits between `fetch`/LSU and the unified memory and handles one outstanding transaction at a time. Data requests have priority, with a starvation guard for fetch and an optional bus-timeout watchdog. Each transaction is accepted with a valid/ready grant and completes with a single-cycle done pulse that carries the read data.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants while fetch waits before fetch is forced; legal range 1..15
- `TIMEOUT_CYC`, 255, cycles to wait for `mem_ack` before abort; used only with `ARB_TIMEOUT_EN`; legal range 1..255

Ports:
- `clk` in 1: sole clock, all state updates on its rising edge
- `rst` in 1: reset, synchronous and active-high
- `if_req` in 1: fetch wants a read
- `if_addr` in AW: fetch address
- `if_gnt` out 1: combinational; fetch request accepted this cycle
- `if_done` out 1: one-cycle completion pulse for fetch
- `if_rdata` out DW: fetched word, valid while `if_done`=1
- `if_err` out 1: fetch completed by timeout, qualified by `if_done`
- `dm_req` in 1: data path wants a read or write
- `dm_we` in 1: 1 = store, 0 = load
- `dm_addr` in AW: data address
- `dm_wdata` in DW: store data
- `dm_gnt`, `dm_done`, `dm_rdata`, `dm_err`: same meaning as the fetch equivalents, for the data path
- `mem_req` out 1: memory transaction active
- `mem_we` out 1: memory write strobe
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_ack` in 1: memory completes the current transaction
- `mem_rdata` in DW: memory read data, valid with `mem_ack`

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- In IDLE, grants are combinational from the state, the requests and the starvation counter:
  - `dm_gnt = dm_req & !(if_req & starve==STARVE_MAX)`
  - `if_gnt = if_req & !dm_gnt`
  - At most one grant is high at a time. Both grants are 0 outside IDLE.
- On a clock edge with a grant:
  - Register the granted request's address, write enable and write data into the mem_* outputs. For fetch, `mem_we`=0 and `mem_wdata`=0.
  - Set `mem_req`=1 and move to the matching BUSY state.
- Each grant consumes one request. A requester that keeps its req high after the grant edge asks for another transaction.
- In BUSY_x, the mem_* outputs are held stable until an edge where `mem_ack`=1 is sampled. On that edge:
  - Clear `mem_req`, pulse `x_done`=1 for one cycle, and return to IDLE.
  - On a read, latch `mem_rdata` into `x_rdata`. Writes leave `dm_rdata` unchanged.
- `mem_ack` sampled in IDLE is ignored.
- Starvation counter `starve` (4-bit, saturating at STARVE_MAX):
  - Increments on each `dm_gnt` edge while `if_req`=1.
  - Clears on each `if_gnt` edge, or when `if_req`=0 in IDLE.
- The read data registers and the mem_* address/data registers hold their values between transactions.

## Timing
- Reset values: `mem_req`/`mem_we`=0, `mem_addr`/`mem_wdata`=0, all done/err=0, all rdata=0, `starve`=0, state IDLE.
- Reset asserted mid-transaction:
  - The transaction is dropped, with no done pulse.
  - `mem_req` is 0 on the cycle after the reset edge.
  - A late `mem_ack` after that is ignored.
- Latency:
  - Grant edge E0, so `mem_req`=1 from E0.
  - Ack sampled at edge En (n≥1), so `x_done` is high for the cycle following En.
  - With zero-wait memory (ack tied high), a transaction occupies 2 cycles: grant at E0, done after E1, next grant possible at E2.
- IDLE lasts at least one cycle between transactions. No grant is issued in the done cycle's predecessor edge.
- A requester must keep addr, we and wdata stable only during the cycle its req is high before the grant. The arbiter captures them at the grant edge.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears at the grant edge and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYC, the next edge aborts the transaction: `mem_req`=0, `x_done`=1, `x_err`=1, `x_rdata`=0, state IDLE.
  - If `mem_ack`=1 on the same edge as the timeout, the ack wins and `x_err`=0.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `if_err`/`dm_err` are tied to 0.
  - The arbiter waits for `mem_ack` indefinitely.

## Test plan
- Single fetch, zero-wait memory: `if_req`=1 for one cycle with `if_addr`=0x10 and `mem_rdata`=0xDEADBEEF, ack tied 1 → `if_gnt`=1 in cycle 0, `mem_addr`=0x10 and `mem_we`=0 in cycle 1, `if_done`=1 with `if_rdata`=0xDEADBEEF in cycle 2.
- Simultaneous requests: `if_req`=`dm_req`=1 held, store to 0x20 with data 0x55 → `dm_gnt` first and `mem_we`=1 with `mem_wdata`=0x55; `dm_rdata` unchanged.
- Starvation guard: `dm_req` and `if_req` held high, STARVE_MAX=4 → data is granted 4 times, then fetch; the pattern repeats D,D,D,D,F.
- Wait states: ack delayed 3 cycles → mem_* outputs stay stable, `if_gnt`/`dm_gnt` stay 0, and `done` arrives on the cycle after the first sampled ack.
- Reset mid-BUSY: `rst`=1 for one cycle during BUSY_DM, then a late `mem_ack` → no `dm_done`, all outputs at reset values, state IDLE.
- `ARB_TIMEOUT_EN` with TIMEOUT_CYC=5 and no ack → `dm_done`=`dm_err`=1 and `dm_rdata`=0 on the 7th cycle after the grant. A second run with ack arriving on the timeout edge → `dm_err`=0.
